// File: rtl/act_readout_if.sv
// Read-port and output-stream bundle between the activation read-out
// engine (master) and the accelerator / host side (slave).
interface act_readout_if #(
    parameter int ADDR_W  = 16,
    parameter int RDATA_W = 32
);
    logic               read_en;
    logic               read_rdy;
    logic [ADDR_W-1:0]  read_addr;
    logic               read_data_rdy;
    logic               read_data_vld;
    logic [RDATA_W-1:0] read_data;
    logic               out_vld;
    logic               out_rdy;
    logic [RDATA_W-1:0] out_data;

    modport master (
        output read_en, read_addr, read_data_rdy, out_vld, out_data,
        input  read_rdy, read_data_vld, read_data, out_rdy
    );

    modport slave (
        input  read_en, read_addr, read_data_rdy, out_vld, out_data,
        output read_rdy, read_data_vld, read_data, out_rdy
    );
endinterface

// File: rtl/act_readout_engine.sv
// Hardware sweep of the accelerator activation memory: address generation,
// credit-limited read requests, index checking and a FWFT output buffer.
module act_readout_engine #(
    parameter int NUM_PE     = 64,
    parameter int PE_W       = 6,
    parameter int ACT_W      = 6,
    parameter int PE_LSB     = 10,
    parameter int ADDR_W     = 16,
    parameter int RDATA_W    = 32,
    parameter int NO_W       = 12,
    parameter int IDX_LSB    = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [NO_W-1:0] act_no,
    input  logic            mode,
    output logic            busy,
    output logic            done,
    output logic            err,
    act_readout_if.master   bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [PE_W-1:0] PE_LAST = PE_W'(NUM_PE - 1);
    localparam logic [CW-1:0]   FULL_C  = CW'(FIFO_DEPTH);
    localparam logic [CW:0]     DEPTH_C = (CW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t             state_q, state_d;
    logic               mode_q;
    logic [NO_W-1:0]    act_no_q, issued_q;
    logic [PE_W-1:0]    pe_q, rpe_q;
    logic [ACT_W-1:0]   act_q, ract_q;
    logic [CW-1:0]      in_flight_q, in_flight_d;
    logic [CW-1:0]      fifo_cnt_q, fifo_cnt_d;
    logic [AW-1:0]      wptr_q, rptr_q;
    logic [RDATA_W-1:0] mem_q [FIFO_DEPTH];
    logic               req_fire, rsp_fire, pop, go, present, idx_bad;
    logic [CW:0]        credit;
    logic [NO_W-1:0]    exp_idx;
    logic [ADDR_W-1:0]  addr_d;

    function automatic logic [PE_W+ACT_W-1:0] step(
        input logic             m,
        input logic [PE_W-1:0]  p,
        input logic [ACT_W-1:0] a
    );
        logic [PE_W-1:0]  pn;
        logic [ACT_W-1:0] an;
        pn = p;
        an = a;
        if (!m) begin
            if (p == PE_LAST) begin
                pn = '0;
                an = a + 1'b1;
            end else begin
                pn = p + 1'b1;
            end
        end else begin
            if (a == '1) begin
                an = '0;
                pn = (p == PE_LAST) ? '0 : p + 1'b1;
            end else begin
                an = a + 1'b1;
            end
        end
        return {pn, an};
    endfunction

    assign req_fire = bus.read_en && bus.read_rdy;
    assign rsp_fire = bus.read_data_vld && bus.read_data_rdy;
    assign pop      = bus.out_vld && bus.out_rdy;
    assign go       = start && (state_q == IDLE);

    // A response moves a credit from in-flight to the FIFO, so only the
    // pop changes the combined occupancy seen by the next request.
    assign credit  = {1'b0, in_flight_q} + {1'b0, fifo_cnt_q}
                   - {{CW{1'b0}}, pop};
    assign present = (state_q == ISSUE) && (!bus.read_en || bus.read_rdy)
                   && (issued_q != act_no_q) && (credit < DEPTH_C);

    assign in_flight_d = in_flight_q + CW'(present) - CW'(rsp_fire);
    assign fifo_cnt_d  = fifo_cnt_q + CW'(rsp_fire) - CW'(pop);

    assign exp_idx = NO_W'(int'(ract_q) * NUM_PE + int'(rpe_q));
    assign idx_bad = bus.read_data[IDX_LSB +: NO_W] != exp_idx;

    always_comb begin
        addr_d = '0;
        addr_d[PE_LSB +: PE_W] = pe_q;
        addr_d[ACT_W-1:0]      = act_q;
    end

    assign busy              = (state_q == ISSUE) || (state_q == DRAIN);
    assign done              = (state_q == DONE);
    assign bus.read_data_rdy = busy && (fifo_cnt_q != FULL_C);
    assign bus.out_vld       = (fifo_cnt_q != '0);
    assign bus.out_data      = bus.out_vld ? mem_q[rptr_q] : '0;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (start) state_d = (act_no == '0) ? DONE : ISSUE;
            ISSUE: if (issued_q == act_no_q && !bus.read_en) state_d = DRAIN;
            DRAIN: if (in_flight_d == '0 && fifo_cnt_d == '0) state_d = DONE;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.read_en   <= 1'b0;
            bus.read_addr <= '0;
            pe_q          <= '0;
            act_q         <= '0;
            issued_q      <= '0;
            mode_q        <= 1'b0;
            act_no_q      <= '0;
        end else if (go) begin
            pe_q     <= '0;
            act_q    <= '0;
            issued_q <= '0;
            mode_q   <= mode;
            act_no_q <= act_no;
        end else if (present) begin
            bus.read_en     <= 1'b1;
            bus.read_addr   <= addr_d;
            {pe_q, act_q}   <= step(mode_q, pe_q, act_q);
            issued_q        <= issued_q + 1'b1;
        end else if (req_fire) begin
            bus.read_en <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_flight_q <= '0;
            rpe_q       <= '0;
            ract_q      <= '0;
            err         <= 1'b0;
        end else begin
            in_flight_q <= in_flight_d;
            if (go) begin
                rpe_q  <= '0;
                ract_q <= '0;
                err    <= 1'b0;
            end else if (rsp_fire) begin
                {rpe_q, ract_q} <= step(mode_q, rpe_q, ract_q);
                if (idx_bad) err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_cnt_q <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
        end else begin
            fifo_cnt_q <= fifo_cnt_d;
            if (rsp_fire) wptr_q <= wptr_q + 1'b1;
            if (pop)      rptr_q <= rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rsp_fire) mem_q[wptr_q] <= bus.read_data;
    end
endmodule

// File: tb/tb_act_readout_engine.sv
// Directed bench for act_readout_engine with an in-order one-cycle
// accelerator responder and a reference address/data sequence model.
module tb_act_readout_engine;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [11:0] act_no;
    logic        mode;
    logic        busy, done, err;

    act_readout_if #(.ADDR_W(16), .RDATA_W(32)) bus ();

    act_readout_engine dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .act_no (act_no),
        .mode   (mode),
        .busy   (busy),
        .done   (done),
        .err    (err),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    int          n_req, n_rsp, n_out, n_done, n_en, peak;
    int          cyc = 0;
    int          last_pop = 0;
    int          corrupt_k = -1;
    bit          cur_mode;
    bit          rdy_rand = 0;
    bit          st_pend = 0;
    bit          err_chk = 0;
    logic [15:0] st_addr;
    logic [31:0] rq[$];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] exp_addr(input int k);
        int p, a;
        p = cur_mode ? k / 64 : k % 64;
        a = cur_mode ? k % 64 : k / 64;
        return 16'((p << 10) | a);
    endfunction

    function automatic logic [31:0] mk_data(input logic [15:0] ad,
                                            input bit bad);
        logic [11:0] idx;
        idx = 12'(int'(ad[5:0]) * 64 + int'(ad[15:10]));
        if (bad) idx = 12'h7FF;
        return {4'hA, idx, ad};
    endfunction

    task automatic tick();
        logic        rf, pf, of;
        logic [15:0] ra;
        logic [31:0] od;
        int          k;
        @(posedge clk);
        cyc++;
        rf = bus.read_en && bus.read_rdy;
        ra = bus.read_addr;
        pf = bus.read_data_vld && bus.read_data_rdy;
        of = bus.out_vld && bus.out_rdy;
        od = bus.out_data;
        if (rst_n) begin
            if (st_pend) begin
                chk("hold_en", bus.read_en, 1'b1);
                chk("hold_addr", ra, st_addr);
            end
            if (err_chk) begin
                chk("err_set", err, 1'b1);
                err_chk = 0;
            end
            if (bus.read_en) n_en++;
            if (rf) chk("addr", ra, exp_addr(n_req));
            if (pf && n_rsp == corrupt_k) begin
                chk("err_before", err, 1'b0);
                err_chk = 1;
            end
            if (of) begin
                chk("out_data", od, mk_data(exp_addr(n_out), n_out == corrupt_k));
                n_out++;
                last_pop = cyc;
            end
            if (done) begin
                n_done++;
                chk("busy_at_done", busy, 1'b0);
                if (n_out > 0) chk("done_lag", cyc, last_pop + 1);
            end
        end
        st_pend = rst_n && bus.read_en && !bus.read_rdy;
        st_addr = ra;
        k = n_req;
        if (rf) n_req++;
        if (pf) n_rsp++;
        if (n_req - n_out > peak) peak = n_req - n_out;
        #1;
        if (!rst_n) begin
            rq.delete();
        end else begin
            if (pf) void'(rq.pop_front());
            if (rf) rq.push_back(mk_data(ra, k == corrupt_k));
        end
        bus.read_data_vld = rq.size() > 0;
        bus.read_data     = (rq.size() > 0) ? rq[0] : 32'h0;
        bus.read_rdy      = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask

    task automatic do_start(input int n, input bit m);
        n_req = 0; n_rsp = 0; n_out = 0; n_done = 0; n_en = 0; peak = 0;
        cur_mode = m;
        act_no = 12'(n);
        mode = m;
        start = 1'b1;
        tick();
        start = 1'b0;
        if (n == 0) begin
            chk("zero_done", done, 1'b1);
            chk("zero_en", bus.read_en, 1'b0);
        end
        tick();
        if (n != 0) begin
            chk("busy_n1", busy, 1'b1);
            chk("en_n1", bus.read_en, 1'b1);
            chk("addr_n1", bus.read_addr, 16'h0);
        end
    endtask

    task automatic finish_sweep(input int n, input bit exp_err);
        for (int i = 0; i < 3000 && n_done == 0; i++) tick();
        tick();
        tick();
        chk("done_cnt", n_done, 1);
        chk("req_cnt", n_req, n);
        chk("out_cnt", n_out, n);
        chk("err_end", err, exp_err);
        chk("peak_le8", peak <= 8, 1'b1);
        chk("idle_busy", busy, 1'b0);
        if (n == 0) chk("no_en", n_en, 0);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_done"}, done, 1'b0);
        chk({tag, "_err"}, err, 1'b0);
        chk({tag, "_en"}, bus.read_en, 1'b0);
        chk({tag, "_addr"}, bus.read_addr, 16'h0);
        chk({tag, "_drdy"}, bus.read_data_rdy, 1'b0);
        chk({tag, "_ovld"}, bus.out_vld, 1'b0);
        chk({tag, "_odata"}, bus.out_data, 32'h0);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        act_no = '0;
        mode = 1'b0;
        bus.read_rdy = 1'b1;
        bus.read_data_vld = 1'b0;
        bus.read_data = '0;
        bus.out_rdy = 1'b1;
        #12;
        chk_reset("rst");
        rst_n = 1'b1;
        tick();

        do_start(130, 1'b0);
        finish_sweep(130, 1'b0);

        do_start(66, 1'b1);
        finish_sweep(66, 1'b1 ^ 1'b1);

        bus.out_rdy = 1'b0;
        do_start(20, 1'b0);
        repeat (50) tick();
        chk("bp_req", n_req, 8);
        chk("bp_out", n_out, 0);
        chk("bp_vld", bus.out_vld, 1'b1);
        chk("bp_drdy", bus.read_data_rdy, 1'b0);
        bus.out_rdy = 1'b1;
        finish_sweep(20, 1'b0);

        rdy_rand = 1;
        do_start(40, 1'b0);
        finish_sweep(40, 1'b0);
        rdy_rand = 0;

        corrupt_k = 5;
        do_start(10, 1'b0);
        finish_sweep(10, 1'b1);
        corrupt_k = -1;
        do_start(3, 1'b1);
        chk("err_clr", err, 1'b0);
        finish_sweep(3, 1'b0);

        do_start(0, 1'b0);
        finish_sweep(0, 1'b0);

        do_start(10, 1'b0);
        repeat (3) tick();
        act_no = 12'd3;
        mode = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_ign", busy, 1'b1);
        finish_sweep(10, 1'b0);

        do_start(30, 1'b0);
        repeat (10) tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset("mid");
        tick();
        tick();
        chk("mid_drdy", bus.read_data_rdy, 1'b0);
        rst_n = 1'b1;
        do_start(4, 1'b1);
        finish_sweep(4, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/act_readout_engine.md
# act_readout_engine

Synthesisable host-side read-out engine for the accelerator's activation memory. After the host issues `start`, the engine performs the full output-activation read sweep across all PEs in hardware: it generates addresses, drives the accelerator read request/response handshake with bounded outstanding requests, checks the activation index embedded in every response, and buffers results into a valid/ready output stream. It sits between the accelerator's read port and the host/DMA side.

## Interface
- `NUM_PE`, 64: PE count; PE index wraps at `NUM_PE-1`.
- `PE_W`, 6: PE index field width.
- `ACT_W`, 6: per-PE activation address field width.
- `PE_LSB`, 10: bit position of the PE field in the read address; activation field at `[ACT_W-1:0]`.
- `ADDR_W`, 16: read address width.
- `RDATA_W`, 32: read data width.
- `NO_W`, 12: activation count width.
- `IDX_LSB`, 16: LSB of the embedded activation index in read data (field is `NO_W` bits).
- `FIFO_DEPTH`, 8: output buffer depth (power of 2, at least 2).

Ports:
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: single-cycle start pulse; accepted only in IDLE.
- `act_no` in `NO_W`: number of activations to read; sampled with `start`.
- `mode` in 1: 0 = interleaved (PE fastest); 1 = PE-blocked (activation address fastest); sampled with `start`.
- `busy` out 1: high from the cycle after accepted `start` until `done`.
- `done` out 1: one-cycle pulse when the sweep completes.
- `err` out 1: sticky index-mismatch flag; cleared by the next accepted `start`.
- `read_en` out 1: read request valid.
- `read_rdy` in 1: accelerator can accept a request.
- `read_addr` out `ADDR_W`: request address; bits outside the two fields are 0.
- `read_data_rdy` out 1: engine can accept a response.
- `read_data_vld` in 1: response valid.
- `read_data` in `RDATA_W`: response data.
- `out_vld` out 1: output stream valid.
- `out_rdy` in 1: downstream ready.
- `out_data` out `RDATA_W`: buffered response, unmodified.

## Operation
- FSM states:
  - IDLE: waits for `start`. On `start` with `act_no` = 0, goes to DONE. Otherwise goes to ISSUE.
  - ISSUE: issues requests until `act_no` requests have been accepted, then goes to DRAIN.
  - DRAIN: waits until all responses are received and the FIFO is empty, then goes to DONE.
  - DONE: lasts one cycle, asserts `done`, then returns to IDLE.
- A request transfers on any edge where `read_en && read_rdy`. A response transfers on any edge where `read_data_vld && read_data_rdy`.
- `read_en` and `read_addr` are registered. Once `read_en` is high, it and `read_addr` hold until the request transfers.
- Address counters `pe`, `act` start at 0.
  - mode 0: `pe` increments; on `pe == NUM_PE-1`, `pe` wraps to 0 and `act` increments.
  - mode 1: `act` increments; on `act == 2^ACT_W-1`, `act` wraps to 0 and `pe` increments.
- Credit rule: a new request may only be presented when `in_flight + fifo_count < FIFO_DEPTH`. A transfer in the same cycle updates both values before the next decision. This guarantees the FIFO never overflows.
- `read_data_rdy` is high in ISSUE and DRAIN whenever the FIFO is not full.
- A response-side copy of the address counters tracks the expected index `act*NUM_PE + pe` (truncated to `NO_W`).
  - If the response field `[IDX_LSB+NO_W-1:IDX_LSB]` differs from the expected index, `err` sets.
  - The mismatched data is still buffered.
- Output FIFO: first-word fall-through from registered storage. A simultaneous push and pop on a full FIFO is legal.
- `start` while not in IDLE is ignored.
- Reset mid-sweep returns everything to reset values. Responses arriving after reset are not accepted, because `read_data_rdy` = 0.

## Timing
- Reset values: `busy`=0, `done`=0, `err`=0, `read_en`=0, `read_addr`=0, `read_data_rdy`=0, `out_vld`=0, `out_data`=0.
- `start` at edge N: `busy`=1 and the first `read_en`=1 with address 0 are valid after edge N+1.
- With `read_rdy` held high and enough credit, one request transfers per cycle.
- A response accepted at edge M gives `out_vld`=1 after edge M (FIFO was empty).
- `done` is high for the single cycle after the last `out_data` pops; `busy` falls with `done`.
- `act_no`=0: `done` pulses the cycle after `start`, and no request is issued.

## Test plan
- Sweep, mode 0, `act_no`=130, `read_rdy`=1, `out_rdy`=1, one-cycle response latency. Required: 130 requests with addresses 0x0000, 0x0400, …, 0xFC00, 0x0001, …, last 0x0402. Required: 130 outputs in order, `err`=0, one `done`.
- Mode 1, `act_no`=66. Required: addresses 0x0000…0x003F, then 0x0400, 0x0401. Indices are checked against `act*64+pe`.
- Backpressure: `out_rdy`=0 for 50 cycles, `act_no`=20. Required: at most 8 requests outstanding-plus-buffered. Required: no response lost, and the stream completes after `out_rdy`=1.
- Stall: `read_rdy` toggled randomly. Required: `read_en` and `read_addr` stable until transfer; no duplicate or skipped address.
- Corrupt the index of response 5 (value 0x7FF). Required: `err`=1 from that edge and held through `done`. Required: `err` cleared by the next `start`.
- Edge cases:
  - `act_no`=0: `done` the cycle after `start`, no `read_en`.
  - `rst_n` low mid-sweep: all outputs go to reset values.
  - `start` while busy: ignored.
